fm_demod: RTL and testbench

Quadrature FM discriminator for the FM radio receive chain. It sits directly downstream of the complex channel FIR and pops one I/Q sample pair from that stage's real and imaginary output FIFOs. For each pair it forms the conjugate product with the previous pair and takes the phase angle using a fixed-point quadrant arctangent with an iterative divider. It scales the angle by a demodulation gain and pushes one signed 32-bit audio-rate sample into a single output FIFO.

---
 rtl/fm_demod.sv | 184 ++++++++++++++++++
 tb/tb_fm_demod.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_demod.sv
// fm_demod: quadrature FM discriminator.
// Pops one I/Q pair from the channel FIR's real/imag FIFOs and forms the
// conjugate product with the previous pair. It takes the phase angle with a
// Q.10 quadrant arctangent, which uses a restoring divider that produces one
// quotient bit per cycle. The angle is scaled by GAIN and one signed sample is
// pushed to the output FIFO.
// Ports:
//   clock, reset               system clock, async active-high reset
//   real_in/real_empty/real_rd_en   I sample FWFT FIFO interface
//   imag_in/imag_empty/imag_rd_en   Q sample FWFT FIFO interface
//   demod_out/demod_wr_en/demod_full output FIFO interface
module fm_demod #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10,
  parameter int GAIN       = 758,
  parameter int QUAD1      = 804,
  parameter int QUAD3      = 2412
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] real_in,
  input  logic                         real_empty,
  output logic                         real_rd_en,
  input  logic signed [DATA_WIDTH-1:0] imag_in,
  input  logic                         imag_empty,
  output logic                         imag_rd_en,
  output logic signed [DATA_WIDTH-1:0] demod_out,
  output logic                         demod_wr_en,
  input  logic                         demod_full
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic signed [DW-1:0] GAIN_V  = DW'(GAIN);
  localparam logic signed [DW-1:0] QUAD1_V = DW'(QUAD1);
  localparam logic signed [DW-1:0] QUAD3_V = DW'(QUAD3);
  localparam logic signed [DW-1:0] ONE_V   = DW'(1);

  typedef enum logic [2:0] {READ, MULT, SETUP, DIVIDE, ANGLE, WRITE} state_t;

  state_t state, next_state;

  logic signed [DW-1:0] cur_r, cur_i, prev_r, prev_i;
  logic signed [DW-1:0] x, y, num, result;
  logic        [DW-1:0] den, rem, dvd, quot;
  logic        [CW-1:0] div_count;

  logic signed [DW-1:0] x_c, y_c, abs_y, num_c, den_c, q_s, a_c, result_c;
  logic        [DW-1:0] num_mag, rem_sub, rem_next;
  logic        [DW:0]   rem_shift;
  logic                 fits;

  // Floor-rounding dequantisation of a double-width product.
  function automatic logic signed [DW-1:0] dequant(input logic signed [2*DW-1:0] v);
    return DW'(v >>> BITS);
  endfunction

  // Full double-width signed multiply.
  function automatic logic signed [2*DW-1:0] mul_wide(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] ae, be;
    ae = $signed({{DW{a[DW-1]}}, a});
    be = $signed({{DW{b[DW-1]}}, b});
    return ae * be;
  endfunction

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= READ;
    else       state <= next_state;
  end

  // Next state and FIFO handshakes. The handshakes are combinational so that
  // a pop or a push costs no extra cycle. They are also held low while reset
  // is asserted.
  always_comb begin
    next_state  = state;
    real_rd_en  = 1'b0;
    imag_rd_en  = 1'b0;
    demod_wr_en = 1'b0;
    demod_out   = '0;
    case (state)
      READ: begin
        if (!reset && !real_empty && !imag_empty) begin
          real_rd_en = 1'b1;
          imag_rd_en = 1'b1;
          next_state = MULT;
        end
      end
      MULT:   next_state = SETUP;
      SETUP:  next_state = DIVIDE;
      DIVIDE: if (div_count == CW'(DW - 1)) next_state = ANGLE;
      ANGLE:  next_state = WRITE;
      WRITE: begin
        if (!demod_full) begin
          demod_wr_en = 1'b1;
          demod_out   = result;
          next_state  = READ;
        end
      end
      default: next_state = READ;
    endcase
  end

  // Arithmetic for each compute step. The divider works on |num| and
  // shifts the dividend MSB into the partial remainder. The sign of num is
  // applied to the quotient afterwards, so the division truncates toward zero.
  always_comb begin
    x_c = dequant(mul_wide(prev_r, cur_r)) + dequant(mul_wide(prev_i, cur_i));
    y_c = dequant(mul_wide(prev_r, cur_i)) - dequant(mul_wide(prev_i, cur_r));

    abs_y = (y[DW-1] ? -y : y) + ONE_V;
    if (!x[DW-1]) begin
      num_c = (x - abs_y) <<< BITS;
      den_c = x + abs_y;
    end else begin
      num_c = (x + abs_y) <<< BITS;
      den_c = abs_y - x;
    end
    num_mag = num_c[DW-1] ? -num_c : num_c;

    rem_shift = {rem, dvd[DW-1]};
    fits      = rem_shift >= {1'b0, den};
    rem_sub   = rem_shift[DW-1:0] - den;
    rem_next  = fits ? rem_sub : rem_shift[DW-1:0];

    q_s = num[DW-1] ? -quot : quot;
    a_c = (x[DW-1] ? QUAD3_V : QUAD1_V) - dequant(mul_wide(QUAD1_V, q_s));
    if (y[DW-1]) a_c = -a_c;
    result_c = dequant(mul_wide(GAIN_V, a_c));
  end

  // Datapath registers. Each one is loaded only in the state that owns it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_r     <= '0;
      cur_i     <= '0;
      prev_r    <= '0;
      prev_i    <= '0;
      x         <= '0;
      y         <= '0;
      num       <= '0;
      den       <= '0;
      rem       <= '0;
      dvd       <= '0;
      quot      <= '0;
      div_count <= '0;
      result    <= '0;
    end else begin
      case (state)
        READ: begin
          if (real_rd_en) begin
            cur_r <= real_in;
            cur_i <= imag_in;
          end
        end
        MULT: begin
          x      <= x_c;
          y      <= y_c;
          prev_r <= cur_r;
          prev_i <= cur_i;
        end
        SETUP: begin
          num       <= num_c;
          den       <= den_c;
          rem       <= '0;
          dvd       <= num_mag;
          quot      <= '0;
          div_count <= '0;
        end
        DIVIDE: begin
          rem       <= rem_next;
          dvd       <= dvd << 1;
          quot      <= {quot[DW-2:0], fits};
          div_count <= div_count + 1'b1;
        end
        ANGLE:   result <= result_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_demod.sv
// tb_fm_demod: self-checking bench for fm_demod.
// A cycle monitor predicts every pop, push and output value from a behavioural
// model: whole-sample arithmetic on ints and longints, plus a pending flag
// that tells when the discriminator is able to accept a new pair.
// Directed scenarios come first, followed by a randomized run with random
// output backpressure.
module tb_fm_demod;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [31:0] real_in, imag_in;
  logic               real_empty, imag_empty;
  logic               real_rd_en, imag_rd_en;
  logic signed [31:0] demod_out;
  logic               demod_wr_en;
  logic               demod_full;

  int check_count = 0;
  int pass_count  = 0;
  int cycle       = 0;

  int  model_prev_r = 0, model_prev_i = 0;
  bit  pending      = 1'b0;
  int  pop_cycle    = 0;
  int  exp_val      = 0;
  int  pop_count    = 0;
  int  write_count  = 0;
  int  last_out     = 0;
  int  last_wr_cycle = 0;
  bit  rand_full    = 1'b0;

  fm_demod dut (
    .clock       (clock),
    .reset       (reset),
    .real_in     (real_in),
    .real_empty  (real_empty),
    .real_rd_en  (real_rd_en),
    .imag_in     (imag_in),
    .imag_empty  (imag_empty),
    .imag_rd_en  (imag_rd_en),
    .demod_out   (demod_out),
    .demod_wr_en (demod_wr_en),
    .demod_full  (demod_full)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  // Count every comparison and report mismatches.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
  endtask

  function automatic int dequant(input longint v);
    longint s;
    s = v >>> 10;
    return int'(s);
  endfunction

  // Behavioural discriminator: one output sample from the previous and the current pair.
  function automatic int demodModel(input int pr, input int pi, input int cr, input int ci);
    int x, y, ay, num, den, q, a;
    int unsigned an, ud, qm;
    x  = dequant(longint'(pr) * longint'(cr)) + dequant(longint'(pi) * longint'(ci));
    y  = dequant(longint'(pr) * longint'(ci)) - dequant(longint'(pi) * longint'(cr));
    ay = (y < 0 ? -y : y) + 1;
    if (x >= 0) begin
      num = (x - ay) <<< 10;
      den = x + ay;
    end else begin
      num = (x + ay) <<< 10;
      den = ay - x;
    end
    an = (num < 0) ? -num : num;
    ud = den;
    qm = (ud == 0) ? 32'hFFFF_FFFF : an / ud;
    q  = (num < 0) ? -int'(qm) : int'(qm);
    a  = ((x >= 0) ? 804 : 2412) - dequant(longint'(804) * longint'(q));
    if (y < 0) a = -a;
    return dequant(longint'(758) * longint'(a));
  endfunction

  // Cycle monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    bit exp_pop, exp_wr;
    if (reset) begin
      pending      = 1'b0;
      model_prev_r = 0;
      model_prev_i = 0;
      checkOutput("rst_rd_en", longint'(real_rd_en), 0);
      checkOutput("rst_wr_en", longint'(demod_wr_en), 0);
      checkOutput("rst_out", longint'(demod_out), 0);
    end else begin
      exp_pop = !pending && !real_empty && !imag_empty;
      checkOutput("real_rd_en", longint'(real_rd_en), longint'(exp_pop));
      checkOutput("imag_rd_en", longint'(imag_rd_en), longint'(exp_pop));
      exp_wr = pending && (cycle >= pop_cycle + 36) && !demod_full;
      checkOutput("wr_en", longint'(demod_wr_en), longint'(exp_wr));
      if (exp_wr) begin
        checkOutput("demod_out", longint'(demod_out), longint'(exp_val));
        pending       = 1'b0;
        last_out      = demod_out;
        last_wr_cycle = cycle;
        write_count++;
      end else begin
        checkOutput("idle_out", longint'(demod_out), 0);
      end
      if (exp_pop) begin
        exp_val      = demodModel(model_prev_r, model_prev_i, real_in, imag_in);
        model_prev_r = real_in;
        model_prev_i = imag_in;
        pending      = 1'b1;
        pop_cycle    = cycle;
        pop_count++;
      end
    end
  end

  task automatic stepCycle();
    @(posedge clock);
    #1;
    if (rand_full) demod_full = ($urandom_range(0, 3) == 0);
  endtask

  // Present a pair on both FIFOs and hold it until it is popped.
  task automatic applyStimulus(input int r, input int i);
    int start, guard;
    real_in    = r;
    imag_in    = i;
    real_empty = 1'b0;
    imag_empty = 1'b0;
    start = pop_count;
    guard = 0;
    while (pop_count == start && guard < 400) begin
      stepCycle();
      guard++;
    end
    checkOutput("pop_timeout", longint'(pop_count != start), 1);
    real_empty = 1'b1;
    imag_empty = 1'b1;
  endtask

  task automatic waitWrite();
    int guard;
    guard = 0;
    while (pending && guard < 400) begin
      stepCycle();
      guard++;
    end
    checkOutput("write_timeout", longint'(pending), 0);
  endtask

  initial begin
    int saved, c_set, sel, gap;
    reset      = 1'b1;
    real_in    = 0;
    imag_in    = 0;
    real_empty = 1'b1;
    imag_empty = 1'b1;
    demod_full = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // First pair after reset: previous sample is zero.
    applyStimulus(0, 0);
    waitWrite();
    checkOutput("zero_pair", longint'(last_out), 1190);
    checkOutput("zero_latency", longint'(last_wr_cycle - pop_cycle), 36);

    // Identical consecutive pairs.
    applyStimulus(1024, 0);
    waitWrite();
    checkOutput("first_1024", longint'(last_out), 1190);
    applyStimulus(1024, 0);
    waitWrite();
    checkOutput("same_phase", longint'(last_out), 1);

    // Negative y with floor rounding.
    applyStimulus(0, -1024);
    waitWrite();
    checkOutput("neg_quadrant", longint'(last_out), -1191);

    // Output backpressure for 10 cycles at WRITE.
    applyStimulus(512, 256);
    demod_full = 1'b1;
    while (cycle < pop_cycle + 46) stepCycle();
    demod_full = 1'b0;
    waitWrite();
    checkOutput("bp_latency", longint'(last_wr_cycle - pop_cycle), 46);
    applyStimulus(-300, 700);
    waitWrite();

    // Only one FIFO non-empty: no pop until both have data.
    real_in    = 2000;
    imag_in    = -50;
    real_empty = 1'b0;
    repeat (20) stepCycle();
    checkOutput("one_empty_no_pop", longint'(pending), 0);
    imag_empty = 1'b0;
    c_set = cycle;
    stepCycle();
    checkOutput("first_both_pop", longint'(pop_cycle), longint'(c_set));
    real_empty = 1'b1;
    imag_empty = 1'b1;
    waitWrite();

    // Reset during DIVIDE discards the sample and clears prev.
    applyStimulus(300, 500);
    while (cycle < pop_cycle + 20) stepCycle();
    reset = 1'b1;
    saved = write_count;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    repeat (40) stepCycle();
    checkOutput("no_write_after_reset", longint'(write_count), longint'(saved));
    applyStimulus(1024, 0);
    waitWrite();
    checkOutput("prev_cleared", longint'(last_out), 1190);
    applyStimulus(0, 0);
    waitWrite();

    // Randomized pairs with idle gaps, one-sided data and random backpressure.
    rand_full = 1'b1;
    for (int n = 0; n < 25; n++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        sel        = $urandom_range(0, 2);
        real_in    = int'($urandom_range(0, 65535)) - 32768;
        imag_in    = int'($urandom_range(0, 65535)) - 32768;
        real_empty = (sel != 1);
        imag_empty = (sel != 2);
        stepCycle();
      end
      applyStimulus(int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768);
    end
    waitWrite();
    rand_full  = 1'b0;
    demod_full = 1'b0;
    repeat (3) stepCycle();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
